// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
//   state_e      - receiver FSM states (PARITY exists only when parity is built in)
//   UART_*       - default frame geometry
//   even_parity  - XOR-reduce; the parity bit that makes the total count of ones even
package uart_pkg;
  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;

  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction
endpackage

// File: rtl/uart_tick_gen.sv
// Sample-tick divider: one-clock tick every BAUD_DIV clocks.
//   clock, reset (async, active-low)
//   clr   - synchronous clear; holds the divider at phase 0
//   tick  - 1-clock strobe
module uart_tick_gen #(
  parameter int BAUD_DIV = 27
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(BAUD_DIV - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)            cnt <= '0;
    else if (clr || tick)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_rx_os.sv
// UART receiver, 16x oversampling, start-bit validation, framing-error pulse.
//   clock, reset (async, active-low)
//   serial     - async line, idle high
//   rx_free    - 1 while waiting for a start bit
//   rx_done    - 1-clock pulse, rx_data holds a new good frame
//   rx_data    - last good frame
//   frame_err  - 1-clock pulse, stop bit sampled low
//   parity_err - (UART_RX_PARITY_EN only) 1-clock pulse, even parity mismatch
// Build option: define UART_RX_PARITY_EN to add an even-parity bit after the data.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int BAUD_DIV   = 27
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 serial,
  output logic                 rx_free,
  output logic                 rx_done,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_err
`ifdef UART_RX_PARITY_EN
  , output logic               parity_err
`endif
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  state_e               state, state_n;
  logic                 s1, s2, line_q;
  logic                 tick, wrap;
  logic [TW-1:0]        tcnt, last_t;
  logic [BW-1:0]        bidx;
  logic [DATA_BITS-1:0] shift;
  logic                 done_n, ferr_n;
`ifdef UART_RX_PARITY_EN
  logic                 pbit, perr_n;
`endif

  wire line = s2;

  // Divider is parked while idle so the first tick lands a full BAUD_DIV after the edge.
  uart_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .clr   (state == IDLE),
    .tick  (tick)
  );

  // START waits half a bit to land mid-bit; every later state waits a whole bit.
  assign last_t = (state == START) ? TW'(OVERSAMPLE / 2 - 1) : TW'(OVERSAMPLE - 1);
  assign wrap   = tick && (tcnt == last_t);
  assign rx_free = (state == IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_n  = 1'b0;
`endif
    case (state)
      IDLE:   if (line_q && !line) state_n = START;
      START:  if (wrap) state_n = line ? IDLE : DATA;
      DATA:   if (wrap && bidx == BW'(DATA_BITS - 1))
`ifdef UART_RX_PARITY_EN
                state_n = PARITY;
      PARITY: if (wrap) state_n = STOP;
`else
                state_n = STOP;
`endif
      STOP: if (wrap) begin
`ifdef UART_RX_PARITY_EN
        perr_n = (even_parity(32'(shift)) != pbit);
`endif
        if (line) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          ferr_n  = 1'b1;
          state_n = BREAK;
        end
      end
      BREAK:   if (line) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1        <= 1'b1;
      s2        <= 1'b1;
      line_q    <= 1'b1;
      tcnt      <= '0;
      bidx      <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbit       <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      s1     <= serial;
      s2     <= s1;
      line_q <= line;
      if (state == IDLE || wrap) tcnt <= '0;
      else if (tick)             tcnt <= tcnt + 1'b1;
      if (state == START)            bidx <= '0;
      else if (state == DATA && wrap) bidx <= bidx + 1'b1;
      // LSB arrives first, so shift right and insert at the top.
      if (state == DATA && wrap) shift <= {line, shift[DATA_BITS-1:1]};
      if (done_n) rx_data <= shift;
      rx_done   <= done_n;
      frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
      if (state == PARITY && wrap) pbit <= line;
      parity_err <= perr_n;
`endif
    end
  end
endmodule

// File: tb/tb_uart_rx_os.sv
// Randomized + directed bench for uart_rx_os (BAUD_DIV=4, OVERSAMPLE=16 -> 64 clocks/bit).
// Honors UART_RX_PARITY_EN when defined.
module tb_uart_rx_os;
  localparam int DB = 8, OS = 16, BD = 4, BITC = OS * BD;
`ifdef UART_RX_PARITY_EN
  localparam int NB = DB + 2;
`else
  localparam int NB = DB + 1;
`endif
  localparam int LAT = NB * BITC + (OS / 2) * BD + 3;

  logic          clock = 1'b0, reset = 1'b0, serial = 1'b1;
  logic          rx_free, rx_done, frame_err;
  logic [DB-1:0] rx_data;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
  int            perr_seen = 0, exp_perr = 0;
`endif

  uart_rx_os #(.DATA_BITS(DB), .OVERSAMPLE(OS), .BAUD_DIV(BD)) dut (
    .clock     (clock),
    .reset     (reset),
    .serial    (serial),
    .rx_free   (rx_free),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .frame_err (frame_err)
`ifdef UART_RX_PARITY_EN
    , .parity_err (parity_err)
`endif
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vec_cnt = 0, err_cnt = 0;
  logic [DB-1:0] got_q[$], exp_q[$];
  int unsigned   got_cyc[$], fall_q[$];
  int            ferr_seen = 0, both_seen = 0, exp_ferr = 0;
  logic [DB-1:0] exp_data = '0;

  always @(negedge clock) begin
    if (reset) begin
      if (rx_done) begin
        got_q.push_back(rx_data);
        got_cyc.push_back(cyc);
      end
      if (frame_err) ferr_seen <= ferr_seen + 1;
      if (rx_done && frame_err) both_seen <= both_seen + 1;
`ifdef UART_RX_PARITY_EN
      if (parity_err) perr_seen <= perr_seen + 1;
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial = b;
    wait_clk(BITC);
  endtask

  // Model: a frame with a high stop bit is delivered, a low one is a framing error.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic par);
    int unsigned f;
    f = cyc;
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
    if (par != ^d) exp_perr++;
`endif
    send_bit(stop);
    if (stop) begin
      exp_q.push_back(d);
      fall_q.push_back(f);
      exp_data = d;
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic check_frames(input string tag);
    int unsigned lat;
    chk({tag, "_ndone"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      chk({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
      lat = got_cyc.pop_front() - fall_q.pop_front();
      chk({tag, "_lat_in_window"}, (lat + 1 >= LAT && lat <= LAT + 1), 1);
    end
    got_q.delete(); got_cyc.delete(); exp_q.delete(); fall_q.delete();
    chk({tag, "_ferr_cnt"}, ferr_seen, exp_ferr);
    chk({tag, "_rx_data"}, rx_data, exp_data);
    chk({tag, "_overlap"}, both_seen, 0);
`ifdef UART_RX_PARITY_EN
    chk({tag, "_perr_cnt"}, perr_seen, exp_perr);
`endif
  endtask

  initial begin
    logic [DB-1:0] d;
    logic          stop, par;

    // reset state
    wait_clk(3);
    chk("rst_free", rx_free, 1);
    chk("rst_done", rx_done, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_data", rx_data, 0);
    reset = 1'b1;
    wait_clk(10);

    // good frame
    send_frame(8'hA5, 1'b1, ^8'hA5);
    wait_clk(4);
    check_frames("a5");
    chk("a5_free", rx_free, 1);

    // short glitch is rejected as a false start
    serial = 1'b0;
    wait_clk(20);
    serial = 1'b1;
    wait_clk(100);
    chk("glitch_free", rx_free, 1);
    check_frames("glitch");

    // bad stop, line held low 3 bit times
    send_frame(8'h3C, 1'b0, ^8'h3C);
    wait_clk(2 * BITC);
    chk("break_busy", rx_free, 0);
    serial = 1'b1;
    wait_clk(5);
    chk("break_free", rx_free, 1);
    check_frames("3c");

    // back-to-back, no idle gap
    send_frame(8'h00, 1'b1, ^8'h00);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    send_frame(8'h55, 1'b1, ^8'h55);
    wait_clk(4);
    check_frames("b2b");

    // reset in the middle of bit 4 of 0x81
    serial = 1'b0;
    wait_clk(BITC);
    for (int i = 0; i < 4; i++) send_bit(logic'((8'h81 >> i) & 1));
    serial = 1'b0;
    wait_clk(BITC / 2);
    reset = 1'b0;
    #1;
    chk("mid_rst_free", rx_free, 1);
    chk("mid_rst_done", rx_done, 0);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_data", rx_data, 0);
    exp_data = '0;
    serial = 1'b1;
    wait_clk(5);
    reset = 1'b1;
    wait_clk(10);
    send_frame(8'h7E, 1'b1, ^8'h7E);
    wait_clk(4);
    check_frames("post_rst");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h01, 1'b1, 1'b0);
    wait_clk(4);
    check_frames("par_bad");
    send_frame(8'h01, 1'b1, 1'b1);
    wait_clk(4);
    check_frames("par_good");
`endif

    // random frames, random stop/parity and gaps
    for (int i = 0; i < 10; i++) begin
      d    = DB'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      par  = ^d;
`ifdef UART_RX_PARITY_EN
      if ($urandom_range(0, 2) == 0) par = ~par;
`endif
      send_frame(d, stop, par);
      if (!stop) begin
        wait_clk($urandom_range(1, 64));
        serial = 1'b1;
        wait_clk(4);
      end
      if ($urandom_range(0, 1) != 0) wait_clk($urandom_range(1, 100));
    end
    wait_clk(8);
    check_frames("rand");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
